// File: rtl/soda_pkg.sv
// Shared definitions for the soda vending controller: state codes, coin encodings, price.
// Helper functions map between credit-holding states and their credit value.
package soda_pkg;

    localparam int PRICE = 3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CRED1  = 3'd1,
        ST_CRED2  = 3'd2,
        ST_VEND   = 3'd3,
        ST_CHANGE = 3'd4
    } state_t;

    localparam logic [1:0] COIN_NONE  = 2'b00;
    localparam logic [1:0] COIN_ONE   = 2'b01;
    localparam logic [1:0] COIN_TWO   = 2'b10;
    localparam logic [1:0] COIN_THREE = 2'b11;

    function automatic logic [2:0] credit_of(state_t s);
        case (s)
            ST_CRED1: credit_of = 3'd1;
            ST_CRED2: credit_of = 3'd2;
            default:  credit_of = 3'd0;
        endcase
    endfunction

    function automatic state_t credit_state(logic [2:0] credit);
        case (credit)
            3'd1:    credit_state = ST_CRED1;
            3'd2:    credit_state = ST_CRED2;
            default: credit_state = ST_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/step_pulse.sv
// Turns the user "next" strobe into a one-clock step pulse on its rising edge.
// Macro NEXT_SYNC_EN inserts a 2-flop synchroniser ahead of the edge detector.
module step_pulse (
    input  logic clk,
    input  logic reset,
    input  logic next,
    output logic step
);

    logic next_s;
    logic next_q;

`ifdef NEXT_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], next};
        end
    end

    assign next_s = sync_q[1];
`else
    assign next_s = next;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            next_q <= 1'b0;
        end else begin
            next_q <= next_s;
        end
    end

    // A held strobe keeps next_q high, so only the first cycle produces a step.
    assign step = next_s & ~next_q;

endmodule

// File: rtl/soda_machine_top.sv
// Coin-operated soda vending controller: credit accumulation, vend at PRICE, change return.
// Macro NEXT_SYNC_EN selects the synchronised step path (see step_pulse).
module soda_machine_top (
    input  logic       clk,
    input  logic       reset,
    input  logic       next,
    input  logic [1:0] coin_in,
    output logic       soda,
    output logic [1:0] coin_out,
    output logic [2:0] state_display
);

    import soda_pkg::*;

    logic       step;
    state_t     state;
    state_t     state_nxt;
    logic [1:0] change_reg;
    logic [1:0] change_nxt;
    logic [2:0] sum;
    logic       soda_nxt;
    logic [1:0] coin_out_nxt;

    step_pulse u_step_pulse (
        .clk   (clk),
        .reset (reset),
        .next  (next),
        .step  (step)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            change_reg <= 2'd0;
            soda       <= 1'b0;
            coin_out   <= COIN_NONE;
        end else begin
            state      <= state_nxt;
            change_reg <= change_nxt;
            soda       <= soda_nxt;
            coin_out   <= coin_out_nxt;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default before the case, so no
        // path leaves a value unassigned and no latch is inferred.
        state_nxt  = state;
        change_nxt = change_reg;
        sum        = credit_of(state) + {1'b0, coin_in};

        case (state)
            ST_IDLE, ST_CRED1, ST_CRED2: begin
                if (step) begin
                    if (sum >= 3'(PRICE)) begin
                        state_nxt  = ST_VEND;
                        change_nxt = 2'(sum - 3'(PRICE));
                    end else begin
                        state_nxt = credit_state(sum);
                    end
                end
            end
            ST_VEND: begin
                if (step) begin
                    state_nxt = (change_reg != 2'd0) ? ST_CHANGE : ST_IDLE;
                end
            end
            ST_CHANGE: begin
                if (step) begin
                    state_nxt  = ST_IDLE;
                    change_nxt = 2'd0;
                end
            end
            default: begin
                // Unreachable codes recover to IDLE without waiting for a step.
                state_nxt  = ST_IDLE;
                change_nxt = 2'd0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        soda_nxt     = 1'b0;
        coin_out_nxt = COIN_NONE;
        if (state_nxt == ST_VEND) begin
            soda_nxt = 1'b1;
        end
        if (state_nxt == ST_CHANGE) begin
            coin_out_nxt = change_nxt;
        end
    end

    assign state_display = state;

endmodule

// File: tb/tb_soda_machine_top.sv
// Self-checking bench for soda_machine_top against a transaction-level vending model.
// Honours NEXT_SYNC_EN for the expected step latency.
module tb_soda_machine_top;

`ifdef NEXT_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       next;
    logic [1:0] coin_in;
    logic       soda;
    logic [1:0] coin_out;
    logic [2:0] state_display;

    int n_checks = 0;
    int n_errors = 0;

    // Model: phase 0 collecting credit, 1 dispensing, 2 returning change.
    int m_credit;
    int m_phase;
    int m_change;

    soda_machine_top dut (
        .clk           (clk),
        .reset         (reset),
        .next          (next),
        .coin_in       (coin_in),
        .soda          (soda),
        .coin_out      (coin_out),
        .state_display (state_display)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] exp_state();
        if (m_phase == 0) return 3'(m_credit);
        if (m_phase == 1) return 3'd3;
        return 3'd4;
    endfunction

    function automatic logic exp_soda();
        return (m_phase == 1);
    endfunction

    function automatic logic [1:0] exp_coin();
        return (m_phase == 2) ? 2'(m_change) : 2'd0;
    endfunction

    task automatic model_reset();
        m_credit = 0;
        m_phase  = 0;
        m_change = 0;
    endtask

    task automatic model_step(input int coin);
        int total;
        if (m_phase == 0) begin
            total = m_credit + coin;
            if (total >= 3) begin
                m_phase  = 1;
                m_change = total - 3;
                m_credit = 0;
            end else begin
                m_credit = total;
            end
        end else if (m_phase == 1) begin
            m_phase = (m_change != 0) ? 2 : 0;
        end else begin
            m_phase  = 0;
            m_change = 0;
        end
    endtask

    // One full press/release of next with coin_in held; returns on a falling edge.
    task automatic apply_step(input logic [1:0] coin);
        @(negedge clk);
        coin_in = coin;
        next    = 1'b1;
        repeat (8) @(negedge clk);
        next = 1'b0;
        repeat (5) @(negedge clk);
        model_step(int'(coin));
        coin_in = 2'($urandom);
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        next    = 1'b0;
        coin_in = 2'b00;
        model_reset();
        #500;
        n_checks++;
        if (state_display !== 3'd0) begin
            n_errors++;
            $display("FAIL reset_state: got %0d, expected 0", state_display);
        end
        n_checks++;
        if (soda !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_soda: got %0b, expected 0", soda);
        end
        n_checks++;
        if (coin_out !== 2'b00) begin
            n_errors++;
            $display("FAIL reset_coin_out: got %0d, expected 0", coin_out);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_sequence(input string name, input logic [1:0] coins [4], input int len);
        for (int i = 0; i < len; i++) begin
            apply_step(coins[i]);
            n_checks++;
            if (state_display !== exp_state() || soda !== exp_soda() || coin_out !== exp_coin()) begin
                n_errors++;
                $display("FAIL %s step%0d: got state=%0d soda=%0b coin_out=%0d, expected state=%0d soda=%0b coin_out=%0d",
                         name, i, state_display, soda, coin_out, exp_state(), exp_soda(), exp_coin());
            end
        end
    endtask

    task automatic test_latency();
        logic [2:0] old_state;
        @(negedge clk);
        old_state = exp_state();
        coin_in   = 2'b10;
        next      = 1'b1;
        repeat (LAT - 1) @(posedge clk);
        #1;
        n_checks++;
        if (state_display !== old_state) begin
            n_errors++;
            $display("FAIL latency_early: got state=%0d, expected %0d", state_display, old_state);
        end
        @(posedge clk);
        #1;
        model_step(2);
        n_checks++;
        if (state_display !== exp_state()) begin
            n_errors++;
            $display("FAIL latency_on_time: got state=%0d, expected %0d", state_display, exp_state());
        end
        repeat (6) @(negedge clk);
        next = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_held_next();
        int         changes;
        logic [2:0] prev;
        changes = 0;
        @(negedge clk);
        prev    = state_display;
        coin_in = 2'b01;
        next    = 1'b1;
        repeat (50) begin
            @(posedge clk);
            #1;
            if (state_display !== prev) begin
                changes++;
                prev = state_display;
            end
        end
        @(negedge clk);
        next = 1'b0;
        repeat (5) @(negedge clk);
        model_step(1);
        n_checks++;
        if (changes !== 1) begin
            n_errors++;
            $display("FAIL held_next_transitions: got %0d, expected 1", changes);
        end
        n_checks++;
        if (state_display !== exp_state() || soda !== exp_soda()) begin
            n_errors++;
            $display("FAIL held_next_state: got state=%0d soda=%0b, expected state=%0d soda=%0b",
                     state_display, soda, exp_state(), exp_soda());
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3 && m_phase != 0; i++) apply_step(2'b00);
        apply_step(2'b10);
        apply_step(2'b11);
        apply_step(2'b00);
        n_checks++;
        if (state_display !== 3'd4 || coin_out !== 2'b10) begin
            n_errors++;
            $display("FAIL mid_reset_setup: got state=%0d coin_out=%0d, expected state=4 coin_out=2",
                     state_display, coin_out);
        end
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        n_checks++;
        if (state_display !== 3'd0 || coin_out !== 2'b00 || soda !== 1'b0) begin
            n_errors++;
            $display("FAIL mid_reset: got state=%0d soda=%0b coin_out=%0d, expected state=0 soda=0 coin_out=0",
                     state_display, soda, coin_out);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_random();
        logic [1:0] coin;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                coin_in = 2'($urandom);
                repeat (10) @(negedge clk);
            end else begin
                coin = 2'($urandom);
                apply_step(coin);
            end
            n_checks++;
            if (state_display !== exp_state() || soda !== exp_soda() || coin_out !== exp_coin()) begin
                n_errors++;
                $display("FAIL random%0d: got state=%0d soda=%0b coin_out=%0d, expected state=%0d soda=%0b coin_out=%0d",
                         i, state_display, soda, coin_out, exp_state(), exp_soda(), exp_coin());
            end
        end
    endtask

    initial begin
        logic [1:0] seq [4];
        test_reset();
        seq = '{2'b01, 2'b00, 2'b00, 2'b00};
        test_sequence("credit", seq, 2);
        seq = '{2'b11, 2'b00, 2'b00, 2'b00};
        test_sequence("vend_change", seq, 3);
        seq = '{2'b11, 2'b00, 2'b00, 2'b00};
        test_sequence("exact_price", seq, 2);
        seq = '{2'b10, 2'b11, 2'b00, 2'b00};
        test_sequence("two_then_three", seq, 4);
        test_latency();
        test_held_next();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
